// File: rtl/cpu_bus_memory.sv
// Byte-wide RAM responder for the cpu_core bus with a framed host loader port.
// The loader owns memory (and holds the CPU) from the command byte through the DONE cycle.
module cpu_bus_memory #(
  parameter int          ADDR_W    = 12,
  parameter logic [7:0]  FILL_BYTE = 8'hEA,
  parameter logic [7:0]  CMD_LOAD  = 8'h55
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_we,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_hold,
  input  logic        ld_valid,
  input  logic [7:0]  ld_data,
  output logic        ld_ready,
  output logic        ld_done,
  output logic        ld_err
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE, S_A_LO, S_A_HI, S_L_LO, S_L_HI, S_DATA, S_DONE
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [15:0] ld_addr;
  logic [15:0] ld_len;
  logic        accept;
  logic        ld_we;
  logic        cpu_wr;
  logic        wr_en;
  logic [ADDR_W-1:0] wr_idx;
  logic [7:0]  wr_data;

  logic [7:0] mem [DEPTH];

  function automatic logic in_range(input logic [15:0] a);
    return (32'(a) >> ADDR_W) == 32'd0;
  endfunction

  // Handshake: a loader byte transfers on a rising clk edge where ld_valid and
  // ld_ready are both 1; ld_ready never depends on ld_valid.
  assign ld_ready = ~reset & (state != S_DONE);
  assign accept   = ld_valid & ld_ready;

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (accept && ld_data == CMD_LOAD) state_next = S_A_LO;
      S_A_LO: if (accept) state_next = S_A_HI;
      S_A_HI: if (accept) state_next = S_L_LO;
      S_L_LO: if (accept) state_next = S_L_HI;
      S_L_HI: if (accept) state_next = ({ld_data, ld_len[7:0]} == 16'd0) ? S_DONE : S_DATA;
      S_DATA: if (accept && ld_len == 16'd1) state_next = S_DONE;
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      ld_addr  <= 16'd0;
      ld_len   <= 16'd0;
      cpu_hold <= 1'b0;
      ld_done  <= 1'b0;
      ld_err   <= 1'b0;
    end else begin
      state    <= state_next;
      cpu_hold <= (state_next != S_IDLE);
      ld_done  <= (state_next == S_DONE);
      ld_err   <= (state == S_IDLE) && accept && (ld_data != CMD_LOAD);
      if (accept) begin
        case (state)
          S_A_LO: ld_addr[7:0]  <= ld_data;
          S_A_HI: ld_addr[15:8] <= ld_data;
          S_L_LO: ld_len[7:0]   <= ld_data;
          S_L_HI: ld_len[15:8]  <= ld_data;
          S_DATA: begin
            ld_addr <= ld_addr + 16'd1;
            ld_len  <= ld_len - 16'd1;
          end
          default: ;
        endcase
      end
    end
  end

  // Loader has priority; a CPU store can only land while the loader is idle.
  always_comb begin
    ld_we   = (state == S_DATA) && accept && in_range(ld_addr);
    cpu_wr  = cpu_we && !cpu_hold && in_range(cpu_addr);
    wr_en   = !reset && (ld_we || cpu_wr);
    wr_idx  = cpu_addr[ADDR_W-1:0];
    wr_data = cpu_wdata;
    if (ld_we) begin
      wr_idx  = ld_addr[ADDR_W-1:0];
      wr_data = ld_data;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cpu_rdata <= 8'h00;
    else       cpu_rdata <= in_range(cpu_addr) ? mem[cpu_addr[ADDR_W-1:0]] : FILL_BYTE;
  end

endmodule

// File: tb/tb_cpu_bus_memory.sv
// Bench for cpu_bus_memory: a 12-bit and a 16-bit instance share all inputs and are
// compared every cycle against a frame-level model of the loader and both memories.
module tb_cpu_bus_memory;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] cpu_addr = 16'h0000;
  logic        cpu_we = 1'b0;
  logic [7:0]  cpu_wdata = 8'h00;
  logic        ld_valid = 1'b0;
  logic [7:0]  ld_data = 8'h00;

  logic [7:0] a_rdata, b_rdata;
  logic       a_hold, a_ready, a_done, a_err;
  logic       b_hold, b_ready, b_done, b_err;

  always #5 clk = ~clk;

  cpu_bus_memory #(.ADDR_W(12)) dut (
    .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_wdata(cpu_wdata),
    .cpu_rdata(a_rdata), .cpu_hold(a_hold), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_ready(a_ready), .ld_done(a_done), .ld_err(a_err));

  cpu_bus_memory #(.ADDR_W(16)) dut16 (
    .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_wdata(cpu_wdata),
    .cpu_rdata(b_rdata), .cpu_hold(b_hold), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_ready(b_ready), .ld_done(b_done), .ld_err(b_err));

  int checks = 0;
  int passed = 0;
  int done_cnt = 0;
  bit cpu_rand = 0;
  logic [7:0] tx_q[$];
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model: frame parser + sparse memories
  bit          busy = 0, done_cyc = 0, err_q = 0;
  int          hdr = 0;
  int          remain = 0;
  logic [7:0]  hb [4];
  logic [15:0] maddr = 16'h0000;
  logic [7:0]  m12 [int];
  logic [7:0]  m16 [int];
  logic [7:0]  e_rd12 = 8'h00, e_rd16 = 8'h00;
  bit          k12 = 1, k16 = 1;

  initial begin
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        busy = 0; done_cyc = 0; err_q = 0; hdr = 0;
        e_rd12 = 8'h00; e_rd16 = 8'h00; k12 = 1; k16 = 1;
      end else begin
        bit acc, hold_now;
        int a;
        acc = ld_valid && !done_cyc;
        hold_now = busy;
        a = int'(cpu_addr);
        if (a < 'h1000) begin
          k12 = m12.exists(a);
          e_rd12 = k12 ? m12[a] : 8'h00;
        end else begin
          k12 = 1; e_rd12 = 8'hEA;
        end
        k16 = m16.exists(a);
        e_rd16 = k16 ? m16[a] : 8'h00;
        if (cpu_we && !hold_now) begin
          if (a < 'h1000) m12[a] = cpu_wdata;
          m16[a] = cpu_wdata;
        end
        err_q = 0;
        if (done_cyc) begin
          done_cyc = 0; busy = 0;
        end else if (acc) begin
          if (!busy) begin
            if (ld_data == 8'h55) begin busy = 1; hdr = 0; end
            else err_q = 1;
          end else if (hdr < 4) begin
            hb[hdr] = ld_data;
            hdr++;
            if (hdr == 4) begin
              maddr = {hb[1], hb[0]};
              remain = int'({hb[3], hb[2]});
              if (remain == 0) done_cyc = 1;
            end
          end else begin
            if (maddr < 16'h1000) m12[int'(maddr)] = ld_data;
            m16[int'(maddr)] = ld_data;
            maddr = maddr + 16'd1;
            remain--;
            if (remain == 0) done_cyc = 1;
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare
  initial begin
    forever begin
      @(negedge clk);
      if (a_done) done_cnt++;
      check("ready12", a_ready, !reset && !done_cyc);
      check("ready16", b_ready, !reset && !done_cyc);
      check("hold12",  a_hold,  busy);
      check("hold16",  b_hold,  busy);
      check("done12",  a_done,  done_cyc);
      check("done16",  b_done,  done_cyc);
      check("err12",   a_err,   err_q);
      check("err16",   b_err,   err_q);
      if (k12) check("rdata12", a_rdata, e_rd12);
      if (k16) check("rdata16", b_rdata, e_rd16);
    end
  end

  // ---------------- driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
    if (cpu_rand) begin
      cpu_addr  = 16'($urandom_range(16'h0FF0, 16'h100F));
      cpu_we    = ($urandom_range(0, 9) < 3);
      cpu_wdata = 8'($urandom_range(0, 255));
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit rdy;
    rdy = 0;
    repeat ($urandom_range(0, gap)) tick();
    ld_valid = 1'b1;
    ld_data  = b;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      rdy = a_ready;
      tick();
      if (rdy) break;
    end
    checks++;
    if (rdy) passed++;
    else $display("FAIL accept_timeout: byte %h not taken, ready=%b", b, a_ready);
    ld_valid = 1'b0;
  endtask

  task automatic send_q(input int gap);
    while (tx_q.size() > 0) send_byte(tx_q.pop_front(), gap);
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    cpu_addr = a; cpu_wdata = d; cpu_we = 1'b1;
    tick();
    cpu_we = 1'b0;
  endtask

  task automatic read_lit(input string name, input logic [15:0] a, input logic [7:0] exp, input bit wide);
    cpu_addr = a;
    tick();
    check(name, wide ? b_rdata : a_rdata, exp);
  endtask

  // ---------------- directed + random sequence
  initial begin
    int d0;
    repeat (2) tick();
    check("rst_rdata", a_rdata, 8'h00);
    check("rst_hold",  a_hold,  1'b0);
    check("rst_ready", a_ready, 1'b0);
    check("rst_done",  a_done,  1'b0);
    check("rst_err",   a_err,   1'b0);
    reset = 1'b0;
    tick();

    // frame into 0x0200
    d0 = done_cnt;
    send_byte(8'h55, 0);
    check("t1_hold_on", a_hold, 1'b1);
    tx_q = '{8'h00, 8'h02, 8'h03, 8'h00, 8'hA9, 8'h42, 8'hEA};
    send_q(0);
    check("t1_done", a_done, 1'b1);
    check("t1_ready_low", a_ready, 1'b0);
    tick();
    check("t1_release", a_hold, 1'b0);
    check("t1_done_once", 16'(done_cnt - d0), 16'd1);
    check("pin_m12_0200", m12['h200], 8'hA9);
    check("pin_m12_0202", m12['h202], 8'hEA);
    read_lit("t2_rd0200", 16'h0200, 8'hA9, 0);
    read_lit("t2_rd0201", 16'h0201, 8'h42, 0);
    read_lit("t2_rd8000", 16'h8000, 8'hEA, 0);

    // CPU stores, read-first, and stores blocked during a frame
    cpu_write(16'h0010, 8'h5A);
    read_lit("t3_rd0010", 16'h0010, 8'h5A, 0);
    cpu_write(16'h0010, 8'h66);
    check("t3_read_first", a_rdata, 8'h5A);
    read_lit("t3_rd0010b", 16'h0010, 8'h66, 0);
    send_byte(8'h55, 0);
    cpu_write(16'h0010, 8'hC3);
    tx_q = '{8'h00, 8'h03, 8'h01, 8'h00, 8'h7E};
    send_q(1);
    tick();
    read_lit("t3_blocked", 16'h0010, 8'h66, 0);
    read_lit("t3_rd0300", 16'h0300, 8'h7E, 0);

    // bad command byte
    send_byte(8'h13, 0);
    check("t4_err", a_err, 1'b1);
    check("t4_hold", a_hold, 1'b0);
    tick();
    check("t4_err_clr", a_err, 1'b0);
    tx_q = '{8'h55, 8'h00, 8'h04, 8'h02, 8'h00, 8'h11, 8'h22};
    send_q(0);
    tick();
    read_lit("t4_rd0401", 16'h0401, 8'h22, 0);

    // address wrap on the 16-bit instance, zero-length frame
    tx_q = '{8'h55, 8'hFF, 8'hFF, 8'h02, 8'h00, 8'h11, 8'h22};
    send_q(1);
    tick();
    read_lit("t5_ffff", 16'hFFFF, 8'h11, 1);
    read_lit("t5_0000", 16'h0000, 8'h22, 1);
    read_lit("t5_0000_12", 16'h0000, 8'h22, 0);
    tx_q = '{8'h55, 8'h00, 8'h02, 8'h00, 8'h00};
    send_q(0);
    check("t5_len0_done", a_done, 1'b1);
    tick();
    read_lit("t5_len0_nowr", 16'h0200, 8'hA9, 0);

    // reset mid-frame
    tx_q = '{8'h55, 8'h00, 8'h01};
    send_q(0);
    check("t6_hold_pre", a_hold, 1'b1);
    reset = 1'b1;
    #1;
    check("t6_hold_async12", a_hold, 1'b0);
    check("t6_hold_async16", b_hold, 1'b0);
    tick();
    reset = 1'b0;
    tick();
    tx_q = '{8'h55, 8'h00, 8'h01, 8'h01, 8'h00, 8'h77};
    send_q(0);
    tick();
    read_lit("t6_rd0100", 16'h0100, 8'h77, 0);

    // random frames around the 12-bit boundary with CPU traffic
    cpu_rand = 1;
    for (int f = 0; f < 14; f++) begin
      logic [15:0] base;
      int len;
      if ($urandom_range(0, 3) == 0) begin
        logic [7:0] bad;
        bad = 8'($urandom_range(0, 255));
        if (bad == 8'h55) bad = 8'h56;
        tx_q.push_back(bad);
      end
      base = 16'($urandom_range(16'h0FF8, 16'h1004));
      len  = $urandom_range(0, 6);
      tx_q.push_back(8'h55);
      tx_q.push_back(base[7:0]);
      tx_q.push_back(base[15:8]);
      tx_q.push_back(8'(len));
      tx_q.push_back(8'h00);
      for (int i = 0; i < len; i++) tx_q.push_back(8'($urandom_range(0, 255)));
      send_q((f % 2 == 0) ? 0 : 3);
    end
    cpu_rand = 0;
    cpu_we = 1'b0;
    repeat (3) tick();

    for (int a = 'h0FF0; a <= 'h100F; a++) begin
      bit kn;
      logic [7:0] ev;
      ev = 8'hEA;
      kn = 1;
      if (a < 'h1000) begin
        kn = m12.exists(a);
        if (kn) ev = m12[a];
      end
      cpu_addr = 16'(a);
      if (kn) exp_q.push_back(ev);
      tick();
      if (kn) check("sweep12", a_rdata, exp_q.pop_front());
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
